// File: rtl/html_token_parser.sv
// Character-stream HTML lexer: requests one character at a time from the reader and
// emits OPEN_TAG / CLOSE_TAG / ATTR / TEXT / END tokens to the layout stage.
module html_token_parser #(
  parameter int CHAR_W       = 8,
  parameter int MAX_NAME     = 4,
  parameter int START_IN_TAG = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  parse_enable,
  output logic                  state_enable,
  input  logic [CHAR_W-1:0]     char,
  input  logic                  has_finished,
  output logic                  token_valid,
  input  logic                  token_ready,
  output logic [2:0]            token_type,
  output logic [8*MAX_NAME-1:0] token_name,
  output logic [7:0]            token_value,
  output logic [CHAR_W-1:0]     token_char,
  output logic                  parse_error,
  output logic                  done,
  output logic [1:0]            dbg_fetch_state,
  output logic [2:0]            dbg_lex_mode
);
  localparam int NAME_W = 8 * MAX_NAME;
  localparam int LEN_W  = $clog2(MAX_NAME + 1);

  localparam logic [2:0] TT_OPEN  = 3'd0;
  localparam logic [2:0] TT_CLOSE = 3'd1;
  localparam logic [2:0] TT_ATTR  = 3'd2;
  localparam logic [2:0] TT_TEXT  = 3'd3;
  localparam logic [2:0] TT_END   = 3'd4;

  localparam logic [CHAR_W-1:0] C_LT = CHAR_W'(8'h3C);
  localparam logic [CHAR_W-1:0] C_GT = CHAR_W'(8'h3E);
  localparam logic [CHAR_W-1:0] C_SL = CHAR_W'(8'h2F);
  localparam logic [CHAR_W-1:0] C_EQ = CHAR_W'(8'h3D);
  localparam logic [CHAR_W-1:0] C_SP = CHAR_W'(8'h20);
  localparam logic [CHAR_W-1:0] C_D0 = CHAR_W'(8'h30);
  localparam logic [CHAR_W-1:0] C_D9 = CHAR_W'(8'h39);

  typedef enum logic [1:0] {F_REQ, F_WAIT, F_EMIT, F_DONE} fetch_e;
  typedef enum logic [2:0] {M_TEXT, M_TAG_OPEN, M_TAG_NAME, M_ATTR_WAIT,
                            M_ATTR_NAME, M_ATTR_VALUE, M_CLOSE_NAME} mode_e;

  localparam mode_e RST_MODE = (START_IN_TAG != 0) ? M_TAG_OPEN : M_TEXT;

  fetch_e              r_fetch, w_fetch_nxt;
  mode_e               r_mode, w_mode_nxt;
  logic [NAME_W-1:0]   r_name, w_name_nxt, w_app_name;
  logic [LEN_W-1:0]    r_name_len, w_len_nxt, w_app_len;
  logic [7:0]          r_value, w_value_nxt, w_value_sat;
  logic [11:0]         w_value_calc;
  logic                r_run;
  logic                r_tok_valid, w_tok_valid_nxt;
  logic [2:0]          r_tok_type, w_tok_type_nxt, w_tok_type;
  logic [NAME_W-1:0]   r_tok_name, w_tok_name_nxt;
  logic [7:0]          r_tok_value, w_tok_value_nxt;
  logic [CHAR_W-1:0]   r_tok_char, w_tok_char_nxt;
  logic                r_err, w_err_nxt;
  logic                r_done, w_done_nxt;
  logic                w_emit, w_is_digit, w_state_enable;

  // Names keep only the first MAX_NAME characters; later ones are dropped silently.
  always_comb begin
    w_app_name = r_name;
    w_app_len  = r_name_len;
    if (int'(r_name_len) < MAX_NAME) begin
      w_app_name[NAME_W-1-8*int'(r_name_len) -: 8] = char[7:0];
      w_app_len = r_name_len + LEN_W'(1);
    end
  end

  assign w_is_digit   = (char >= C_D0) && (char <= C_D9);
  assign w_value_calc = 12'(r_value) * 12'd10 + {8'd0, char[3:0]};
  assign w_value_sat  = (w_value_calc > 12'd255) ? 8'hFF : w_value_calc[7:0];

  // Token handshake: token_valid rises with stable token fields and holds them
  // until the cycle where token_valid & token_ready are both high.
  always_comb begin
    w_fetch_nxt     = r_fetch;
    w_mode_nxt      = r_mode;
    w_name_nxt      = r_name;
    w_len_nxt       = r_name_len;
    w_value_nxt     = r_value;
    w_err_nxt       = r_err;
    w_done_nxt      = r_done;
    w_tok_valid_nxt = r_tok_valid;
    w_tok_type_nxt  = r_tok_type;
    w_tok_name_nxt  = r_tok_name;
    w_tok_value_nxt = r_tok_value;
    w_tok_char_nxt  = r_tok_char;
    w_state_enable  = 1'b0;
    w_emit          = 1'b0;
    w_tok_type      = TT_TEXT;
    case (r_fetch)
      F_REQ: begin
        if (parse_enable && r_run) begin
          w_state_enable = 1'b1;
          w_fetch_nxt    = F_WAIT;
        end
      end
      F_WAIT: begin
        if (has_finished) begin
          w_emit     = 1'b1;
          w_tok_type = TT_END;
          if (r_mode != M_TEXT) w_err_nxt = 1'b1;
        end else begin
          case (r_mode)
            M_TEXT: begin
              if (char == C_LT) begin
                w_mode_nxt = M_TAG_OPEN;
                w_name_nxt = '0;
                w_len_nxt  = '0;
              end else begin
                w_emit     = 1'b1;
                w_tok_type = TT_TEXT;
              end
            end
            M_TAG_OPEN: begin
              if (char == C_SL) w_mode_nxt = M_CLOSE_NAME;
              else if (char == C_GT) begin
                w_err_nxt  = 1'b1;
                w_mode_nxt = M_TEXT;
              end else begin
                w_name_nxt = w_app_name;
                w_len_nxt  = w_app_len;
                w_mode_nxt = M_TAG_NAME;
              end
            end
            M_TAG_NAME: begin
              if (char == C_SP || char == C_GT) begin
                w_emit     = 1'b1;
                w_tok_type = TT_OPEN;
                w_mode_nxt = (char == C_SP) ? M_ATTR_WAIT : M_TEXT;
              end else begin
                w_name_nxt = w_app_name;
                w_len_nxt  = w_app_len;
              end
            end
            M_ATTR_WAIT: begin
              if (char == C_GT) w_mode_nxt = M_TEXT;
              else if (char == C_EQ) w_err_nxt = 1'b1;
              else if (char != C_SP) begin
                w_name_nxt = {char[7:0], {(NAME_W-8){1'b0}}};
                w_len_nxt  = LEN_W'(1);
                w_mode_nxt = M_ATTR_NAME;
              end
            end
            M_ATTR_NAME: begin
              if (char == C_EQ) begin
                w_value_nxt = '0;
                w_mode_nxt  = M_ATTR_VALUE;
              end else if (char == C_GT) begin
                w_err_nxt  = 1'b1;
                w_mode_nxt = M_TEXT;
              end else begin
                w_name_nxt = w_app_name;
                w_len_nxt  = w_app_len;
              end
            end
            M_ATTR_VALUE: begin
              if (w_is_digit) w_value_nxt = w_value_sat;
              else if (char == C_SP || char == C_GT) begin
                w_emit     = 1'b1;
                w_tok_type = TT_ATTR;
                w_mode_nxt = (char == C_SP) ? M_ATTR_WAIT : M_TEXT;
              end else w_err_nxt = 1'b1;
            end
            M_CLOSE_NAME: begin
              if (char == C_GT) begin
                w_emit     = 1'b1;
                w_tok_type = TT_CLOSE;
                w_mode_nxt = M_TEXT;
              end else begin
                w_name_nxt = w_app_name;
                w_len_nxt  = w_app_len;
              end
            end
            default: w_mode_nxt = M_TEXT;
          endcase
        end
        w_fetch_nxt = w_emit ? F_EMIT : F_REQ;
        if (w_emit) begin
          w_tok_valid_nxt = 1'b1;
          w_tok_type_nxt  = w_tok_type;
          w_tok_name_nxt  = (w_tok_type == TT_TEXT || w_tok_type == TT_END) ? '0 : r_name;
          w_tok_value_nxt = (w_tok_type == TT_ATTR) ? r_value : 8'd0;
          w_tok_char_nxt  = (w_tok_type == TT_TEXT) ? char : '0;
        end
      end
      F_EMIT: begin
        if (token_ready) begin
          w_tok_valid_nxt = 1'b0;
          if (r_tok_type == TT_END) begin
            w_fetch_nxt = F_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_fetch_nxt = F_REQ;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_fetch     <= F_REQ;
      r_mode      <= RST_MODE;
      r_name      <= '0;
      r_name_len  <= '0;
      r_value     <= '0;
      r_run       <= 1'b0;
      r_tok_valid <= 1'b0;
      r_tok_type  <= TT_OPEN;
      r_tok_name  <= '0;
      r_tok_value <= '0;
      r_tok_char  <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_fetch     <= w_fetch_nxt;
      r_mode      <= w_mode_nxt;
      r_name      <= w_name_nxt;
      r_name_len  <= w_len_nxt;
      r_value     <= w_value_nxt;
      r_run       <= 1'b1;
      r_tok_valid <= w_tok_valid_nxt;
      r_tok_type  <= w_tok_type_nxt;
      r_tok_name  <= w_tok_name_nxt;
      r_tok_value <= w_tok_value_nxt;
      r_tok_char  <= w_tok_char_nxt;
      r_err       <= w_err_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign state_enable    = w_state_enable;
  assign token_valid     = r_tok_valid;
  assign token_type      = r_tok_type;
  assign token_name      = r_tok_name;
  assign token_value     = r_tok_value;
  assign token_char      = r_tok_char;
  assign parse_error     = r_err;
  assign done            = r_done;
  assign dbg_fetch_state = r_fetch;
  assign dbg_lex_mode    = r_mode;
endmodule

// File: tb/tb_html_token_parser.sv
// Bench for html_token_parser: a reader model feeds strings, a string-level lexer
// model predicts the token list, and every observed token is compared in order.
module tb_html_token_parser;
  localparam int W = 51;
  localparam string DEFAULT_S = "body><p color=7 size=2 >test</p></body>";

  logic        clock = 1'b0;
  logic        resetn;
  logic        parse_enable;
  logic        state_enable;
  logic [7:0]  char;
  logic        has_finished;
  logic        token_valid;
  logic        token_ready;
  logic [2:0]  token_type;
  logic [31:0] token_name;
  logic [7:0]  token_value;
  logic [7:0]  token_char;
  logic        parse_error;
  logic        done;
  logic [1:0]  dbg_fetch_state;
  logic [2:0]  dbg_lex_mode;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  bit    exp_err;
  string rd_s = "";
  int    rd_ptr = 0;
  int    req_cnt = 0;
  bit    rand_ready = 0;

  html_token_parser #(.CHAR_W(8), .MAX_NAME(4), .START_IN_TAG(1)) dut (
    .clock(clock), .resetn(resetn), .parse_enable(parse_enable),
    .state_enable(state_enable), .char(char), .has_finished(has_finished),
    .token_valid(token_valid), .token_ready(token_ready), .token_type(token_type),
    .token_name(token_name), .token_value(token_value), .token_char(token_char),
    .parse_error(parse_error), .done(done),
    .dbg_fetch_state(dbg_fetch_state), .dbg_lex_mode(dbg_lex_mode)
  );

  always #5 clock = ~clock;

  // Reader: answers each request on the following cycle, then signals end-of-stream.
  always @(posedge clock) begin
    if (state_enable) begin
      req_cnt++;
      if (rd_ptr < rd_s.len()) begin
        char         <= rd_s[rd_ptr];
        has_finished <= 1'b0;
        rd_ptr++;
      end else begin
        char         <= 8'd0;
        has_finished <= 1'b1;
      end
    end
  end

  always @(negedge clock)
    if (token_valid && token_ready)
      obs_q.push_back({token_type, token_name, token_value, token_char});

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pack_name(input string nm);
    logic [31:0] r = '0;
    for (int k = 0; k < 4 && k < nm.len(); k++) r[31-8*k -: 8] = nm[k];
    return r;
  endfunction

  task automatic push_tok(input int t, input string nm, input int v, input byte c);
    exp_q.push_back({3'(t), pack_name(nm), 8'(v), 8'(c)});
  endtask

  // String-level lexer: walks text runs, tags and attribute lists directly.
  task automatic model_run(input string s, input bit start_tag);
    int i; int n; bit in_tag; string nm; int v;
    exp_q.delete(); exp_err = 0; i = 0; n = s.len(); in_tag = start_tag;
    forever begin
      if (!in_tag) begin
        while (i < n && s[i] != "<") begin push_tok(3, "", 0, s[i]); i++; end
        if (i >= n) begin push_tok(4, "", 0, 0); return; end
        i++;
      end
      in_tag = 0;
      if (i >= n) begin exp_err = 1; push_tok(4, "", 0, 0); return; end
      if (s[i] == ">") begin exp_err = 1; i++; continue; end
      if (s[i] == "/") begin
        i++; nm = "";
        while (i < n && s[i] != ">") begin nm = {nm, s.substr(i, i)}; i++; end
        if (i >= n) begin exp_err = 1; push_tok(4, "", 0, 0); return; end
        push_tok(1, nm, 0, 0); i++; continue;
      end
      nm = s.substr(i, i); i++;
      while (i < n && s[i] != " " && s[i] != ">") begin nm = {nm, s.substr(i, i)}; i++; end
      if (i >= n) begin exp_err = 1; push_tok(4, "", 0, 0); return; end
      push_tok(0, nm, 0, 0);
      if (s[i] == ">") begin i++; continue; end
      i++;
      forever begin
        while (i < n && (s[i] == " " || s[i] == "=")) begin
          if (s[i] == "=") exp_err = 1;
          i++;
        end
        if (i >= n) begin exp_err = 1; push_tok(4, "", 0, 0); return; end
        if (s[i] == ">") begin i++; break; end
        nm = s.substr(i, i); i++;
        while (i < n && s[i] != "=" && s[i] != ">") begin nm = {nm, s.substr(i, i)}; i++; end
        if (i >= n) begin exp_err = 1; push_tok(4, "", 0, 0); return; end
        if (s[i] == ">") begin exp_err = 1; i++; break; end
        i++; v = 0;
        while (i < n && s[i] != " " && s[i] != ">") begin
          if (s[i] >= "0" && s[i] <= "9") begin
            v = v * 10 + int'(s[i]) - 48;
            if (v > 255) v = 255;
          end else exp_err = 1;
          i++;
        end
        if (i >= n) begin exp_err = 1; push_tok(4, "", 0, 0); return; end
        push_tok(2, nm, v, 0);
        if (s[i] == ">") begin i++; break; end
        i++;
      end
    end
  endtask

  task automatic restart(input string s);
    resetn = 1'b0;
    rd_s = s; rd_ptr = 0; obs_q.delete();
    model_run(s, 1'b1);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(posedge clock); #1;
      if (rand_ready) token_ready = 1'($urandom_range(0, 1));
      k++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic compare_tokens(input string tag);
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s_tok%0d", tag, k), 64'(obs_q[k]), 64'(exp_q[k]));
    check({tag, "_err"}, 64'(parse_error), 64'(exp_err));
  endtask

  task automatic check_no_req_after_done(input string tag);
    int r = req_cnt;
    repeat (6) @(posedge clock);
    #1 check({tag, "_no_req"}, 64'(req_cnt), 64'(r));
  endtask

  function automatic string rand_name();
    string s = "";
    int n = $urandom_range(1, 6);
    for (int k = 0; k < n; k++) s = {s, $sformatf("%c", 8'(97 + $urandom_range(0, 25)))};
    return s;
  endfunction

  function automatic string gen_stream();
    string pool = "abcxyz019 =/>";
    string s;
    int pick;
    s = {rand_name(), ">"};
    repeat ($urandom_range(3, 8)) begin
      case ($urandom_range(0, 5))
        0, 5: repeat ($urandom_range(1, 4)) begin
          pick = $urandom_range(0, pool.len() - 1);
          s = {s, pool.substr(pick, pick)};
        end
        1, 2: begin
          s = {s, "<", rand_name()};
          repeat ($urandom_range(0, 2))
            s = {s, " ", rand_name(), "=", $sformatf("%0d", $urandom_range(0, 400))};
          if ($urandom_range(0, 7) == 0) s = {s, "x"};
          s = {s, ($urandom_range(0, 1) == 1) ? " >" : ">"};
        end
        3: s = {s, "</", rand_name(), ">"};
        default: case ($urandom_range(0, 2))
          0: s = {s, "<>"};
          1: s = {s, "<a =b=1>"};
          default: s = {s, "<q b>"};
        endcase
      endcase
    end
    if ($urandom_range(0, 4) == 0) s = s.substr(0, $urandom_range(0, s.len() - 1));
    return s;
  endfunction

  initial begin
    int r;
    int k;
    string rem;
    resetn = 1'b0; parse_enable = 1'b1; token_ready = 1'b1;
    rd_s = DEFAULT_S; rd_ptr = 0;
    model_run(DEFAULT_S, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 64'(token_valid), 64'd0);
    check("rst_se", 64'(state_enable), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(parse_error), 64'd0);
    check("rst_name", 64'(token_name), 64'd0);
    check("model_first", 64'(exp_q[0]), 64'({3'd0, 32'h626F6479, 8'd0, 8'd0}));
    resetn = 1'b1;
    wait_done("default", 2000);
    compare_tokens("default");
    check_no_req_after_done("default");

    // first token stalled for five cycles
    token_ready = 1'b0;
    restart(DEFAULT_S);
    k = 0;
    while (!token_valid && k < 60) begin @(posedge clock); #1; k++; end
    check("stall_valid_seen", 64'(token_valid), 64'd1);
    r = req_cnt;
    repeat (5) begin
      @(negedge clock);
      check("stall_valid", 64'(token_valid), 64'd1);
      check("stall_name", 64'(token_name), 64'h626F6479);
      check("stall_no_se", 64'(state_enable), 64'd0);
    end
    check("stall_req_cnt", 64'(req_cnt), 64'(r));
    @(posedge clock); #1 token_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("stall_next_req", 64'(state_enable), 64'd1);
    wait_done("stall", 2000);
    compare_tokens("stall");

    restart("p size=300>");
    wait_done("sat", 500);
    compare_tokens("sat");
    check("sat_value", 64'((obs_q.size() > 1) ? obs_q[1][15:8] : 8'd0), 64'd255);

    restart("p size=2x>");
    wait_done("junk", 500);
    compare_tokens("junk");
    check("junk_value", 64'((obs_q.size() > 1) ? obs_q[1][15:8] : 8'd0), 64'd2);

    // pause requests mid-stream
    restart(DEFAULT_S);
    repeat (12) @(posedge clock);
    #1 parse_enable = 1'b0;
    repeat (4) @(posedge clock);
    #1 r = req_cnt;
    repeat (10) begin
      @(negedge clock);
      check("pause_se", 64'(state_enable), 64'd0);
    end
    check("pause_req_cnt", 64'(req_cnt), 64'(r));
    @(posedge clock); #1 parse_enable = 1'b1;
    wait_done("pause", 2000);
    compare_tokens("pause");

    restart("p col");
    wait_done("eos_attr", 500);
    compare_tokens("eos_attr");
    check_no_req_after_done("eos_attr");

    // reset while a token is pending; parser resumes from the reader's position
    token_ready = 1'b0;
    restart(DEFAULT_S);
    k = 0;
    while (!token_valid && k < 60) begin @(posedge clock); #1; k++; end
    check("mid_valid_seen", 64'(token_valid), 64'd1);
    @(posedge clock); #1 resetn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(token_valid), 64'd0);
    check("mid_rst_se", 64'(state_enable), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(posedge clock); #1;
    resetn = 1'b1; token_ready = 1'b1;
    rem = (rd_ptr < rd_s.len()) ? rd_s.substr(rd_ptr, rd_s.len() - 1) : "";
    model_run(rem, 1'b1);
    obs_q.delete();
    @(posedge clock);
    @(negedge clock);
    check("mid_first_req", 64'(state_enable), 64'd1);
    wait_done("mid", 2000);
    compare_tokens("mid");

    rand_ready = 1;
    for (int t = 0; t < 30; t++) begin
      restart(gen_stream());
      wait_done($sformatf("rnd%0d", t), 5000);
      compare_tokens($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/html_token_parser.md
Name: html_token_parser

Overview:
- Consumer end of the character-stream interface that reader blocks drive with `state_enable`, `char` and `has_finished`.
- Pulls one character per request and lexes a restricted HTML subset: tags, `name=number` attributes and text.
- Emits one token per lexical event on a valid/ready interface to the layout stage.
- Sits between the reading stage and rendering/layout.

Parameters:
- CHAR_W, 8, character width in bits. Matches the codebase `CHAR_BITES` width.
- MAX_NAME, 4, number of characters stored per tag or attribute name.
- START_IN_TAG, 1, when 1 the parser starts as if `<` was already consumed. The reader's stream begins after the first `<`.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- parse_enable  in  1  when 0, no new character requests are issued. Tokens already in flight still complete.
- state_enable  out  1  character request to the reader. High for exactly one cycle per request.
- char  in  CHAR_W  character from the reader. Valid the cycle after the request.
- has_finished  in  1  reader end-of-stream. Checked in the same cycle as `char`.
- token_valid  out  1  token available.
- token_ready  in  1  downstream accepts the token.
- token_type  out  3  0=OPEN_TAG, 1=CLOSE_TAG, 2=ATTR, 3=TEXT, 4=END.
- token_name  out  8*MAX_NAME  tag or attribute name, left-justified. Character i occupies bits [8*MAX_NAME-1-8i -: 8]. Unused bytes are 0.
- token_value  out  8  attribute value. 0 for other token types.
- token_char  out  CHAR_W  text character for TEXT tokens. 0 otherwise.
- parse_error  out  1  sticky malformed-input flag.
- done  out  1  high after the END token is accepted.

Behaviour:
- Reset (async, resetn=0):
  - All outputs 0; fetch FSM to REQ.
  - Lexical mode to TAG_OPEN if START_IN_TAG=1, else TEXT.
  - Name and value accumulators cleared.
  - The reader has no reset, so a mid-stream reset resumes at the reader's current position. The parser does not resynchronise.
- Fetch FSM:
  - REQ: if parse_enable=1, drive state_enable=1 for one cycle, then go to WAIT. Otherwise hold with state_enable=0.
  - WAIT: state_enable=0.
    - If has_finished=1: load an END token and go to EMIT (then DONE).
    - Otherwise apply the lexical rules to `char`. If a token results, go to EMIT; else go to REQ.
  - EMIT: token_valid=1, outputs stable. On token_valid & token_ready, go to REQ (or DONE after END) and token_valid falls.
  - DONE: done=1, state_enable=0 forever until reset.
- Timing:
  - The request/response pair is a minimum of 2 cycles, which guarantees state_enable returns low between requests as the reader requires.
  - A token character with token_ready tied high costs 3 cycles.
  - No request is issued while token_valid=1.
- Lexical modes (evaluated in WAIT):
  - TEXT:
    - `<` → TAG_OPEN; clear name.
    - Any other character → TEXT token with token_char=char.
  - TAG_OPEN:
    - `/` → CLOSE_NAME.
    - `>` → set parse_error, go to TEXT.
    - Otherwise append to name → TAG_NAME.
  - TAG_NAME:
    - space → OPEN_TAG token, go to ATTR_WAIT.
    - `>` → OPEN_TAG token, go to TEXT.
    - Otherwise append.
  - ATTR_WAIT:
    - space → ignored.
    - `>` → TEXT, no token.
    - `=` → parse_error, ignored.
    - Otherwise clear name, append, go to ATTR_NAME.
  - ATTR_NAME:
    - `=` → value=0, go to ATTR_VALUE.
    - `>` → parse_error, go to TEXT.
    - Otherwise append.
  - ATTR_VALUE:
    - Digit d → value = value*10 + d, saturating at 255.
    - space → ATTR token, go to ATTR_WAIT.
    - `>` → ATTR token, go to TEXT.
    - Other character → parse_error, ignored.
  - CLOSE_NAME:
    - `>` → CLOSE_TAG token, go to TEXT.
    - Otherwise append.
- Name append: characters beyond MAX_NAME are dropped silently; the stored name is truncated with no error.
- Token outputs are registered. token_name and token_value hold for the whole EMIT phase.
- has_finished takes priority over `char` in the same cycle. END is emitted exactly once, whatever the lexical mode. If the mode is not TEXT at that point, parse_error is set.

Test Plan:
- Default stream `body><p color=7 size=2 >test</p></body>` with token_ready=1 → tokens in order:
  - OPEN 0x626F6479
  - OPEN 0x70000000
  - ATTR 0x636F6C6F value 7
  - ATTR 0x73697A65 value 2
  - TEXT t, e, s, t
  - CLOSE 0x70000000
  - CLOSE 0x626F6479
  - END
  - then done=1 and parse_error=0.
- token_ready held 0 for 5 cycles on the first token → token_valid and 0x626F6479 stable throughout, no state_enable pulse; the next request is issued 1 cycle after ready.
- Value `size=300` → token_value=255 (saturated). `size=2x` → parse_error=1 and value 2.
- parse_enable=0 mid-stream → state_enable stays 0. Re-enable → the sequence resumes with no lost or duplicated character.
- has_finished asserted while in ATTR_NAME → single END token, parse_error=1, done=1, no further requests.
- resetn pulsed low mid-EMIT → token_valid, state_enable and done read 0 immediately; after release the first request is issued within 1 cycle.
